// File: rtl/util_clock_div_mc.sv
`default_nettype none
// ============================================================================
// util_clock_div_mc : NCH-channel programmable integer clock divider with
//                     boundary-aligned ratio updates and reset release.
// Revision 1.0 - initial release
// ============================================================================
module util_clock_div_mc #(
   parameter int NCH         = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 40,
   parameter int RST_HOLD    = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*DIV_W-1:0] div_par,
   input  logic [NCH-1:0]       en,
   output logic [NCH-1:0]       clk_div,
   output logic [NCH-1:0]       rise_stb,
   output logic [NCH-1:0]       rst_out,
   output logic [NCH-1:0]       upd_pend
);

   localparam logic [DIV_W-1:0] DEF_R    = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE_R    = DIV_W'(1);
   localparam logic [3:0]       HOLD_LST = 4'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_BYP  = 2'd2
   } state_t;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DIV_W-1:0] div_raw;
      logic [DIV_W-1:0] div_dec;
      logic [DIV_W-1:0] pend;
      logic [DIV_W-1:0] act;
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] hi;
      state_t           state;
      logic             clk_v;
      logic             byp_q;
      logic             stb;
      logic             rst_rel;
      logic [3:0]       rcnt;
      logic             boundary;
      logic             start;

      assign div_raw  = div_par[i*DIV_W +: DIV_W];
      assign div_dec  = (div_raw == '0) ? DEF_R : div_raw;
      assign hi       = act - (act >> 1);

      // Bypass has no internal phase, so every cycle is a period boundary.
      assign boundary = (state == ST_IDLE) || (state == ST_BYP) ||
                        ((state == ST_DIV) && (cnt == act - 1'b1));
      assign start    = en[i] && boundary;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pend    <= DEF_R;
            act     <= DEF_R;
            cnt     <= '0;
            state   <= ST_IDLE;
            clk_v   <= 1'b0;
            byp_q   <= 1'b0;
            stb     <= 1'b0;
            rcnt    <= '0;
            rst_rel <= 1'b0;
         end else begin
            pend <= div_dec;
            if (boundary) begin
               act <= pend;
               cnt <= '0;
               if (en[i]) begin
                  state <= (pend == ONE_R) ? ST_BYP : ST_DIV;
                  clk_v <= (pend != ONE_R);
                  byp_q <= (pend == ONE_R);
                  stb   <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  clk_v <= 1'b0;
                  byp_q <= 1'b0;
                  stb   <= 1'b0;
               end
            end else begin
               cnt   <= cnt + 1'b1;
               clk_v <= ((cnt + 1'b1) < hi);
               stb   <= 1'b0;
            end
            // Counted on the edge that raises rise_stb so release lands in that cycle.
            if (start && !rst_rel) begin
               rcnt <= rcnt + 1'b1;
               if (rcnt == HOLD_LST) begin
                  rst_rel <= 1'b1;
               end
            end
         end
      end

      assign clk_div[i]  = clk_v | (clk & byp_q);
      assign rise_stb[i] = stb;
      assign rst_out[i]  = rst_rel;
      assign upd_pend[i] = (pend != act);
   end

endmodule
`default_nettype wire

// File: tb/tb_util_clock_div_mc.sv
`default_nettype none
// ============================================================================
// tb_util_clock_div_mc : randomized self-checking bench with a period-queue
//                        reference model. Revision 1.0
// ============================================================================
module tb_util_clock_div_mc;
   localparam int NCH         = 2;
   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 40;
   localparam int RST_HOLD    = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH*DIV_W-1:0] div_par = '0;
   logic [NCH-1:0]       en = '0;
   logic [NCH-1:0]       clk_div;
   logic [NCH-1:0]       rise_stb;
   logic [NCH-1:0]       rst_out;
   logic [NCH-1:0]       upd_pend;

   util_clock_div_mc #(
      .NCH(NCH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV), .RST_HOLD(RST_HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .div_par(div_par), .en(en),
      .clk_div(clk_div), .rise_stb(rise_stb), .rst_out(rst_out), .upd_pend(upd_pend)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Each queued entry is one future cycle: bit0 high phase, bit1 bypass, bit2 rise.
   int q [NCH][$];
   int act_m [NCH];
   int pend_m [NCH];
   int cur_m [NCH];
   int nstb [NCH];
   int cyc;
   int prev_rise [NCH];
   int high_acc [NCH];
   int last_per [NCH];
   int last_hi [NCH];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
      end
   endtask

   function automatic int dec(input int d);
      return (d == 0) ? DEFAULT_DIV : d;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         q[c].delete();
         act_m[c]     = DEFAULT_DIV;
         pend_m[c]    = DEFAULT_DIV;
         cur_m[c]     = 0;
         nstb[c]      = 0;
         prev_rise[c] = -1;
         high_acc[c]  = 0;
         last_per[c]  = 0;
         last_hi[c]   = 0;
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < NCH; c++) begin
         if (q[c].size() == 0) begin
            act_m[c] = pend_m[c];
            if (en[c]) begin
               if (act_m[c] == 1) q[c].push_back(6);
               else begin
                  for (int k = 0; k < act_m[c]; k++)
                     q[c].push_back(((k == 0) ? 4 : 0) | ((k < act_m[c] - act_m[c] / 2) ? 1 : 0));
               end
            end
         end
         cur_m[c]  = (q[c].size() != 0) ? q[c].pop_front() : 0;
         pend_m[c] = dec(int'(div_par[c*DIV_W +: DIV_W]));
         if ((cur_m[c] & 4) != 0) nstb[c]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("clk_div_high_half[%0d]", c), int'(clk_div[c]), int'((cur_m[c] & 3) != 0));
         chk($sformatf("rise_stb[%0d]", c), int'(rise_stb[c]), int'((cur_m[c] & 4) != 0));
         chk($sformatf("rst_out[%0d]", c), int'(rst_out[c]), int'(nstb[c] >= RST_HOLD));
         chk($sformatf("upd_pend[%0d]", c), int'(upd_pend[c]), int'(pend_m[c] != act_m[c]));
         if (rise_stb[c]) begin
            if (prev_rise[c] >= 0) begin
               last_per[c] = cyc - prev_rise[c];
               last_hi[c]  = high_acc[c];
            end
            prev_rise[c] = cyc;
            high_acc[c]  = 0;
         end
      end
      cyc++;
      @(negedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("clk_div_low_half[%0d]", c), int'(clk_div[c]), cur_m[c] & 1);
         high_acc[c] += int'(clk_div[c]);
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic set_div(input int c, input int v);
      div_par[c*DIV_W +: DIV_W] = DIV_W'(v);
   endtask

   task automatic wait_rise(input int c);
      int guard;
      guard = 0;
      tick();
      while (!rise_stb[c] && guard < 300) begin
         tick();
         guard++;
      end
      chk($sformatf("rise_timeout[%0d]", c), int'(rise_stb[c]), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_clk_div"}, int'(clk_div), 0);
      chk({tag, "_rise_stb"}, int'(rise_stb), 0);
      chk({tag, "_rst_out"}, int'(rst_out), 0);
      chk({tag, "_upd_pend"}, int'(upd_pend), 0);
   endtask

   task automatic random_phase(input int n);
      int c;
      int r;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(19, 0) == 0) begin
            c = int'($urandom_range(NCH - 1, 0));
            r = int'($urandom_range(15, 0));
            if (r < 10) set_div(c, r);
            else set_div(c, int'($urandom_range(2 ** DIV_W - 1, 0)));
         end
         if ($urandom_range(29, 0) == 0) begin
            c = int'($urandom_range(NCH - 1, 0));
            en[c] = ~en[c];
         end
         tick();
      end
   endtask

   initial begin
      int cnt;
      cyc = 0;
      model_reset();
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Default ratio on both channels.
      en = '1;
      run(100);
      chk("default_period", last_per[0], 40);
      chk("default_high", last_hi[0], 20);
      chk("default_rst_out", int'(rst_out), 3);

      set_div(0, 5);
      set_div(1, 2);
      run(60);
      chk("div5_period", last_per[0], 5);
      chk("div5_high", last_hi[0], 3);
      chk("div2_period", last_per[1], 2);
      chk("div2_high", last_hi[1], 1);

      set_div(0, 255);
      run(600);
      chk("div255_period", last_per[0], 255);
      chk("div255_high", last_hi[0], 128);

      // Mid-period ratio change from 4 to 7.
      set_div(0, 4);
      run(280);
      wait_rise(0);
      set_div(0, 7);
      tick();
      chk("midchange_upd_pend", int'(upd_pend[0]), 1);
      run(30);
      chk("div7_period", last_per[0], 7);
      chk("div7_high", last_hi[0], 4);

      // Enable gating during a high phase of ratio 6.
      set_div(0, 6);
      run(20);
      wait_rise(0);
      tick();
      en[0] = 1'b0;
      run(12);
      chk("gated_clk_div", int'(clk_div[0]), 0);
      en[0] = 1'b1;
      tick();
      chk("reenable_rise", int'(rise_stb[0]), 1);

      // Bypass entered from idle, then back to a divided ratio.
      en[0] = 1'b0;
      run(10);
      set_div(0, 1);
      run(2);
      en[0] = 1'b1;
      tick();
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         cnt += int'(rise_stb[0]);
      end
      chk("bypass_stb_count", cnt, 5);
      set_div(0, 3);
      run(12);
      chk("div3_period", last_per[0], 3);
      chk("div3_high", last_hi[0], 2);

      random_phase(4000);

      // Asynchronous reset during a high phase with different ratios.
      en = '1;
      set_div(0, 9);
      set_div(1, 4);
      run(60);
      cnt = 0;
      while (!clk_div[0] && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("pre_reset_high", int'(clk_div[0]), 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(40);

      random_phase(2500);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
